// File: rtl/ut_enc_pkg.sv
// Shared types, constants and calendar tables for the ut_encode block.
// UT_ENC_CHECK_EN (see ut_encode.sv) uses month_len for day-of-month validation.
package ut_enc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CALC    = 2'd2,
    OUT     = 2'd3
  } ut_state_e;

  localparam int EPOCH_YEAR       = 1970;
  localparam int EPOCH_DOW        = 4;
  localparam int SEC_PER_DAY      = 86400;
  localparam int DIGITS_PER_FRAME = 14;
  localparam int LAST_CALC_STEP   = 3;

  // Days before the first of month m in a non-leap year; 0 outside 1..12.
  function automatic logic [15:0] cum_days(input logic [5:0] m);
    case (m)
      6'd1:    return 16'd0;
      6'd2:    return 16'd31;
      6'd3:    return 16'd59;
      6'd4:    return 16'd90;
      6'd5:    return 16'd120;
      6'd6:    return 16'd151;
      6'd7:    return 16'd181;
      6'd8:    return 16'd212;
      6'd9:    return 16'd243;
      6'd10:   return 16'd273;
      6'd11:   return 16'd304;
      6'd12:   return 16'd334;
      default: return 16'd0;
    endcase
  endfunction

  function automatic logic [5:0] month_len(input logic [5:0] m, input logic leap);
    case (m)
      6'd2:                   return leap ? 6'd29 : 6'd28;
      6'd4, 6'd6, 6'd9, 6'd11: return 6'd30;
      6'd1, 6'd3, 6'd5, 6'd7,
      6'd8, 6'd10, 6'd12:     return 6'd31;
      default:                return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/ut_encode_if.sv
// Digit-stream input and result output bundle for ut_encode.
interface ut_encode_if;
  // Valid-only protocol, no ready: the source holds in_valid high for 14
  // consecutive cycles with one BCD digit per cycle; the block answers with a
  // single-cycle out_valid pulse, and out_time/out_day are zero otherwise.
  logic        in_valid;
  logic [3:0]  in_digit;
  logic        out_valid;
  logic [30:0] out_time;
  logic [2:0]  out_day;

  modport master (
    output in_valid,
    output in_digit,
    input  out_valid,
    input  out_time,
    input  out_day
  );

  modport slave (
    input  in_valid,
    input  in_digit,
    output out_valid,
    output out_time,
    output out_day
  );
endinterface

// File: rtl/ut_day_count.sv
// Combinational (year, month, day) -> days since 1970-01-01.
// Y%4 leap rule is exact over 1970..2037.
module ut_day_count
  import ut_enc_pkg::*;
(
  input  logic [10:0] year_i,
  input  logic [5:0]  month_i,
  input  logic [5:0]  day_i,
  output logic [15:0] days_o
);

  logic [10:0] yoff;
  logic [15:0] yoff_w;
  logic [15:0] leap_adj;

  always_comb begin
    yoff     = year_i - 11'(EPOCH_YEAR);
    yoff_w   = {5'd0, yoff};
    leap_adj = (month_i > 6'd2 && year_i[1:0] == 2'b00) ? 16'd1 : 16'd0;
    // (yoff + 1) / 4 counts leap years strictly before year_i, starting at 1972.
    days_o   = yoff_w * 16'd365
             + ((yoff_w + 16'd1) >> 2)
             + cum_days(month_i)
             + leap_adj
             + {10'd0, day_i}
             - 16'd1;
  end

endmodule

// File: rtl/ut_encode.sv
// Serial BCD date/time (YYYYMMDDhhmmss) to 31-bit Unix time and day of week.
// Optional input validation is built when UT_ENC_CHECK_EN is defined.
module ut_encode
  import ut_enc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  ut_encode_if.slave bus,
  output ut_state_e  dbg_state_o
);

  ut_state_e   state_q;
  logic [3:0]  cnt_q;
  logic [10:0] year_q;
  logic [5:0]  mon_q;
  logic [5:0]  day_q;
  logic [5:0]  hour_q;
  logic [5:0]  min_q;
  logic [5:0]  sec_q;
  logic [15:0] days_q;
  logic [16:0] sod_q;
  logic [30:0] prod_q;
  logic [30:0] sum_q;
  logic [2:0]  dow_q;
  logic        out_valid_q;
  logic [30:0] out_time_q;
  logic [2:0]  out_day_q;

  logic [3:0]  dig;
  logic [10:0] year_base;
  logic [10:0] year_next;
  logic [5:0]  fld_cur;
  logic [5:0]  fld_next;
  logic [15:0] days_w;
  logic [16:0] sod_d;
  logic [30:0] prod_d;
  logic [30:0] sum_d;
  logic [2:0]  dow_d;

  assign dig = bus.in_digit;

  // Decimal accumulation: the field addressed by the digit index absorbs one digit.
  always_comb begin
    year_base = (state_q == IDLE) ? 11'd0 : year_q;
    year_next = year_base * 11'd10 + {7'd0, dig};
    case (cnt_q)
      4'd4, 4'd5:   fld_cur = mon_q;
      4'd6, 4'd7:   fld_cur = day_q;
      4'd8, 4'd9:   fld_cur = hour_q;
      4'd10, 4'd11: fld_cur = min_q;
      default:      fld_cur = sec_q;
    endcase
    fld_next = fld_cur * 6'd10 + {2'd0, dig};
  end

  ut_day_count u_day_count (
    .year_i  (year_q),
    .month_i (mon_q),
    .day_i   (day_q),
    .days_o  (days_w)
  );

  always_comb begin
    sod_d  = {11'd0, hour_q} * 17'd3600 + {11'd0, min_q} * 17'd60 + {11'd0, sec_q};
    prod_d = {15'd0, days_q} * 31'(SEC_PER_DAY);
    sum_d  = prod_q + {14'd0, sod_q};
    dow_d  = 3'((days_q + 16'(EPOCH_DOW)) % 16'd7);
  end

`ifdef UT_ENC_CHECK_EN
  logic        bad_q;
  logic [14:0] year_wide;
  logic [9:0]  fld_wide;
  logic        digit_bad;
  logic        acc_bad;
  logic        range_bad;

  // Wide copies catch digit sequences that would wrap a field back into range.
  always_comb begin
    year_wide = {4'd0, year_base} * 15'd10 + {11'd0, dig};
    fld_wide  = {4'd0, fld_cur} * 10'd10 + {6'd0, dig};
    digit_bad = dig > 4'd9;
    acc_bad   = (cnt_q < 4'd4) ? (year_wide > 15'd2047) : (fld_wide > 10'd63);
    range_bad = (year_q < 11'd1970) || (year_q > 11'd2037)
             || (mon_q == 6'd0) || (mon_q > 6'd12)
             || (day_q == 6'd0) || (day_q > month_len(mon_q, year_q[1:0] == 2'b00))
             || (hour_q > 6'd23) || (min_q > 6'd59) || (sec_q > 6'd59);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      year_q      <= '0;
      mon_q       <= '0;
      day_q       <= '0;
      hour_q      <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      days_q      <= '0;
      sod_q       <= '0;
      prod_q      <= '0;
      sum_q       <= '0;
      dow_q       <= '0;
      out_valid_q <= 1'b0;
      out_time_q  <= '0;
      out_day_q   <= '0;
`ifdef UT_ENC_CHECK_EN
      bad_q       <= 1'b0;
`endif
    end else begin
      out_valid_q <= 1'b0;
      out_time_q  <= '0;
      out_day_q   <= '0;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            state_q <= COLLECT;
            cnt_q   <= 4'd1;
            year_q  <= year_next;
            mon_q   <= '0;
            day_q   <= '0;
            hour_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
`ifdef UT_ENC_CHECK_EN
            bad_q   <= digit_bad | acc_bad;
`endif
          end
        end
        COLLECT: begin
          if (!bus.in_valid) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            case (cnt_q)
              4'd1, 4'd2, 4'd3: year_q <= year_next;
              4'd4, 4'd5:       mon_q  <= fld_next;
              4'd6, 4'd7:       day_q  <= fld_next;
              4'd8, 4'd9:       hour_q <= fld_next;
              4'd10, 4'd11:     min_q  <= fld_next;
              default:          sec_q  <= fld_next;
            endcase
`ifdef UT_ENC_CHECK_EN
            bad_q <= bad_q | digit_bad | acc_bad;
`endif
            if (cnt_q == 4'(DIGITS_PER_FRAME - 1)) begin
              state_q <= CALC;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        CALC: begin
          cnt_q <= cnt_q + 4'd1;
          case (cnt_q)
            4'd0: begin
              days_q <= days_w;
              sod_q  <= sod_d;
`ifdef UT_ENC_CHECK_EN
              bad_q  <= bad_q | range_bad;
`endif
            end
            4'd1: prod_q <= prod_d;
            4'd2: begin
              sum_q <= sum_d;
              dow_q <= dow_d;
            end
            default: begin
              // Result registers load on the same edge that enters OUT.
              state_q     <= OUT;
              cnt_q       <= '0;
              out_valid_q <= 1'b1;
`ifdef UT_ENC_CHECK_EN
              out_time_q  <= bad_q ? 31'h7FFF_FFFF : sum_q;
              out_day_q   <= bad_q ? 3'd7 : dow_q;
`else
              out_time_q  <= sum_q;
              out_day_q   <= dow_q;
`endif
            end
          endcase
        end
        OUT: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_time  = out_time_q;
  assign bus.out_day   = out_day_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_ut_encode.sv
// Bench for ut_encode: directed and random dates against a calendar model.
// Define UT_ENC_CHECK_EN to also exercise the invalid-frame path.
module tb_ut_encode;
  import ut_enc_pkg::*;

  typedef logic [3:0] frame_t [14];
  localparam int W = 34;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  ut_state_e dbg_state;
  int        cyc = 0;
  int        errors = 0;
  int        checks = 0;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];

  ut_encode_if bus ();

  ut_encode dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- model ----------------
  function automatic bit is_leap(input int y);
    return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
  endfunction

  function automatic int mlen(input int y, input int mo);
    if (mo == 2) return is_leap(y) ? 29 : 28;
    if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
    return 31;
  endfunction

  function automatic int model_days(input int y, input int mo, input int d);
    int n = 0;
    for (int yy = 1970; yy < y; yy++) n += is_leap(yy) ? 366 : 365;
    for (int mm = 1; mm < mo; mm++) n += mlen(y, mm);
    return n + d - 1;
  endfunction

  function automatic frame_t mk(input int y, input int mo, input int d,
                                input int h, input int mi, input int s);
    frame_t f;
    f[0]  = 4'(y / 1000);
    f[1]  = 4'((y / 100) % 10);
    f[2]  = 4'((y / 10) % 10);
    f[3]  = 4'(y % 10);
    f[4]  = 4'(mo / 10);
    f[5]  = 4'(mo % 10);
    f[6]  = 4'(d / 10);
    f[7]  = 4'(d % 10);
    f[8]  = 4'(h / 10);
    f[9]  = 4'(h % 10);
    f[10] = 4'(mi / 10);
    f[11] = 4'(mi % 10);
    f[12] = 4'(s / 10);
    f[13] = 4'(s % 10);
    return f;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; returns #1 after the edge that sampled the last digit.
  task automatic drive_frame(input frame_t f, input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_digit = f[i];
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_digit = 4'd0;
  endtask

  task automatic push_exp(input longint t, input int d);
    exp_q.push_back({31'(t), 3'(d)});
    exp_cyc_q.push_back(cyc + 4);
  endtask

  // Covers CALC and OUT; optional junk on in_valid must be ignored there.
  task automatic finish_frame(input bit junk, input int gap);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.in_digit = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_digit = 4'd0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_lit(input frame_t f, input longint t, input int d);
    drive_frame(f, 14);
    push_exp(t, d);
    finish_frame(1'b0, 0);
  endtask

  task automatic send_model(input int y, input int mo, input int d,
                            input int h, input int mi, input int s, input bit junk);
    longint t;
    int days;
    days = model_days(y, mo, d);
    t = longint'(days) * 86400 + h * 3600 + mi * 60 + s;
    drive_frame(mk(y, mo, d, h, mi, s), 14);
    push_exp(t, (days + 4) % 7);
    finish_frame(junk, int'($urandom_range(0, 2)));
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    int ec;
    if (!rst_n) begin
      check("rst_valid", bus.out_valid, 0);
      check("rst_time", bus.out_time, 0);
      check("rst_day", bus.out_day, 0);
      check("rst_state", dbg_state, IDLE);
    end else if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("latency", cyc, ec);
        check("out_time", bus.out_time, e[W-1:3]);
        check("out_day", bus.out_day, e[2:0]);
      end
    end else begin
      check("idle_zero", {bus.out_time, bus.out_day}, 0);
      if (exp_cyc_q.size() != 0 && cyc > exp_cyc_q[0]) begin
        check("missing_valid", 0, 1);
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int y, mo, d;
    bus.in_valid = 1'b0;
    bus.in_digit = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    check("model_epoch", model_days(1970, 1, 1), 0);
    check("model_2000_03_01", model_days(2000, 3, 1), 11017);
    check("model_2037_12_31", model_days(2037, 12, 31), 24836);

    send_lit(mk(1970, 1, 1, 0, 0, 0), 0, 4);
    send_lit(mk(2000, 3, 1, 0, 0, 0), 951868800, 3);
    send_lit(mk(2022, 10, 31, 12, 34, 56), 1667219696, 1);
    send_lit(mk(2037, 12, 31, 23, 59, 59), 2145916799, 4);

    // Aborted after 8 digits, then a full frame.
    drive_frame(mk(2011, 5, 17, 8, 9, 10), 8);
    @(posedge clk); #1;
    send_lit(mk(1970, 1, 2, 0, 0, 0), 86400, 5);

    // Reset asserted in the middle of CALC: no pulse may follow.
    drive_frame(mk(2015, 6, 30, 23, 59, 59), 14);
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
    end

    // Boundary days and leap handling.
    send_model(2024, 2, 29, 1, 2, 3, 1'b0);
    send_model(2023, 2, 28, 23, 59, 59, 1'b1);
    send_model(1972, 12, 31, 0, 0, 1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      y  = int'($urandom_range(1970, 2037));
      mo = int'($urandom_range(1, 12));
      d  = int'($urandom_range(1, mlen(y, mo)));
      send_model(y, mo, d, int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                 int'($urandom_range(0, 59)), 1'($urandom_range(0, 1)));
    end

`ifdef UT_ENC_CHECK_EN
    begin
      frame_t f;
      send_lit(mk(2023, 2, 29, 0, 0, 0), 31'h7FFF_FFFF, 7);
      send_lit(mk(2038, 1, 1, 0, 0, 0), 31'h7FFF_FFFF, 7);
      send_lit(mk(1999, 13, 1, 0, 0, 0), 31'h7FFF_FFFF, 7);
      send_lit(mk(2000, 1, 1, 24, 0, 0), 31'h7FFF_FFFF, 7);
      f = mk(2001, 4, 5, 6, 7, 8);
      f[9] = 4'hA;
      send_lit(f, 31'h7FFF_FFFF, 7);
      send_lit(mk(2001, 4, 31, 0, 0, 0), 31'h7FFF_FFFF, 7);
      send_model(2001, 4, 30, 6, 7, 8, 1'b0);
    end
`endif

    repeat (8) @(posedge clk);
    #1;
    check("drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
